// File: rtl/spi_ram_burst.sv
// Burst-capable RAM endpoint behind the SPI slave: command decode, independent
// auto-incrementing read/write pointers and a READ_LAT-deep read pipeline.
// Optional per-word even parity is compiled in with `define RAM_PARITY_EN.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err,
  output logic              par_err
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic [MEM_W-1:0]  r_mem [0:MEM_DEPTH-1];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_addr_err;
  logic              r_s1_vld;
  logic              r_s1_perr;
  logic [DATA_W-1:0] r_s1_data;

  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_ld_wr;
  logic              w_wr_en;
  logic              w_ld_rd;
  logic              w_rd_en;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_perr;

  assign w_cmd     = din[DATA_W+1:DATA_W];
  assign w_addr    = din[ADDR_W-1:0];
  assign w_data    = din[DATA_W-1:0];
  assign w_ld_wr   = rx_valid && (w_cmd == 2'b00);
  assign w_wr_en   = rx_valid && (w_cmd == 2'b01);
  assign w_ld_rd   = rx_valid && (w_cmd == 2'b10);
  assign w_rd_en   = rx_valid && (w_cmd == 2'b11);
  assign w_rd_word = r_mem[r_rd_ptr];
  assign w_rd_data = w_rd_word[DATA_W-1:0];

`ifdef RAM_PARITY_EN
  assign w_wr_word = {even_par(w_data), w_data};
  assign w_rd_perr = even_par(w_rd_data) ^ w_rd_word[DATA_W];
`else
  assign w_wr_word = w_data;
  assign w_rd_perr = 1'b0;
`endif

  // Storage array: deliberately not reset, write commits at the sampling edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  // Pointer management and rejected-load error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      if (w_ld_wr) begin
        if (addr_ok(w_addr)) r_wr_ptr <= w_addr;
        else                 r_addr_err <= 1'b1;
      end else if (w_wr_en) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_ld_rd) begin
        if (addr_ok(w_addr)) r_rd_ptr <= w_addr;
        else                 r_addr_err <= 1'b1;
      end else if (w_rd_en) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
    end
  end

  // First read stage; its data register only loads on a read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_perr <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld  <= w_rd_en;
      r_s1_perr <= w_rd_en & w_rd_perr;
      if (w_rd_en) begin
        r_s1_data <= w_rd_data;
      end
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign dout     = r_s1_data;
      assign tx_valid = r_s1_vld;
      assign par_err  = r_s1_perr;
    end else begin : g_lat2
      logic              r_s2_vld;
      logic              r_s2_perr;
      logic [DATA_W-1:0] r_s2_data;

      // Second read stage feeding the SPI shifter.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_vld  <= 1'b0;
          r_s2_perr <= 1'b0;
          r_s2_data <= '0;
        end else begin
          r_s2_vld  <= r_s1_vld;
          r_s2_perr <= r_s1_perr;
          if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign dout     = r_s2_data;
      assign tx_valid = r_s2_vld;
      assign par_err  = r_s2_perr;
    end
  endgenerate

  assign addr_err = r_addr_err;

endmodule
